mem_stage_access: RTL

Memory-stage access controller and MEM/WB pipeline register for the pipelined MIPS datapath. It consumes the EX/MEM register outputs and drives a data memory over a req/ack handshake with variable latency. It stalls the front of the pipeline while an access is outstanding and registers the writeback fields for the WB stage. It also flags misaligned and timed-out accesses.

---
 rtl/mem_stage_access.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM-stage data memory access controller and MEM/WB pipeline register
module mem_stage_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    input  logic        RegWriteM,
    input  logic [31:0] ALUresultM,
    input  logic [31:0] ReadData2M,
    input  logic [4:0]  WriteRegM,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWData,
    input  logic        DmemAck,
    input  logic [31:0] DmemRData,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUresultW,
    output logic [4:0]  WriteRegW,
    output logic        MemErr,
    output logic [31:0] ErrAddr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;

    logic        w_access;
    logic        w_aligned;
    logic        w_req;
    logic        w_stall;
    logic        w_complete;
    logic        w_err;
    state_t      w_state_next;
    logic [7:0]  w_cnt_next;

    assign w_access  = MemReadM | MemWriteM;
    assign w_aligned = (ALUresultM[1:0] == 2'b00);

    // Decode the current cycle: request, stall, completion or error, plus next FSM/counter values
    always_comb begin
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        w_err        = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (!w_aligned) begin
                        w_err = 1'b1;
                    end else begin
                        w_req = 1'b1;
                        if (DmemAck) begin
                            w_complete = 1'b1;
                        end else begin
                            w_stall      = 1'b1;
                            w_state_next = S_WAIT;
                            w_cnt_next   = 8'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // A late ack on the timeout cycle still completes the access
                if (DmemAck) begin
                    w_req        = 1'b1;
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = 8'd0;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_req      = 1'b1;
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // Request and stall are gated by reset so an abandoned access drops immediately
    assign DmemReq   = Rst_n & w_req;
    assign StallM    = Rst_n & w_stall;
    assign DmemWe    = MemWriteM;
    assign DmemAddr  = ALUresultM;
    assign DmemWData = ReadData2M;

    // Access FSM state and wait counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // MEM/WB register: capture on pass-through or completion, bubble on stall/error
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWriteW  <= 1'b0;
            MemToRegW  <= 1'b0;
            ReadDataW  <= 32'd0;
            ALUresultW <= 32'd0;
            WriteRegW  <= 5'd0;
        end else if (w_complete) begin
            RegWriteW  <= RegWriteM;
            MemToRegW  <= MemToRegM;
            ReadDataW  <= MemWriteM ? 32'd0 : DmemRData;
            ALUresultW <= ALUresultM;
            WriteRegW  <= WriteRegM;
        end else if (w_stall || w_err) begin
            // Data fields hold; only the control bits are squashed
            RegWriteW  <= 1'b0;
            MemToRegW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            MemToRegW  <= MemToRegM;
            ReadDataW  <= 32'd0;
            ALUresultW <= ALUresultM;
            WriteRegW  <= WriteRegM;
        end
    end

    // Sticky error flag; the address of the first faulting access is kept
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            MemErr  <= 1'b0;
            ErrAddr <= 32'd0;
        end else if (w_err) begin
            MemErr <= 1'b1;
            if (!MemErr) begin
                ErrAddr <= ALUresultM;
            end
        end
    end

endmodule
